// File: rtl/pushpop_sequencer.sv
// pushpop_sequencer: multi-cycle sequencer for Thumb PUSH/POP register lists.
// Stalls fetch, issues one memory access per listed register (ascending
// offsets from the current SP), applies one SP update, then pulses done_o.
// Optional feature macro: PUSHPOP_TIMEOUT_EN adds an ACCESS wait counter that
// aborts the instruction with an err_o pulse after WAIT_LIMIT stalled cycles.
module pushpop_sequencer #(
    parameter logic [3:0] SP_REG = 4'd13,
    parameter logic [3:0] LR_REG = 4'd14,
    parameter logic [3:0] PC_REG = 4'd15
`ifdef PUSHPOP_TIMEOUT_EN
    ,
    parameter int WAIT_LIMIT = 16
`endif
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        mem_ready_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        mem_write_o,
    output logic        mem_load_o,
    output logic [3:0]  reg_sel_o,
    output logic [5:0]  off_o,
    output logic        rf_write_en_o,
    output logic        pc_load_o,
    output logic        sp_write_en_o,
    output logic        sp_dec_o,
    output logic [5:0]  sp_delta_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SP_UPD = 3'd1;
    localparam logic [2:0] ACCESS = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
`ifdef PUSHPOP_TIMEOUT_EN
    localparam logic [2:0] ABORT  = 3'd4;
    localparam int         WAIT_W = $clog2(WAIT_LIMIT + 1);
`endif

    logic [2:0] r_state;
    logic [8:0] r_list;
    logic       r_push;
    logic [3:0] r_count;
    logic [3:0] r_k;

    logic [2:0] w_state_next;
    logic [8:0] w_list_next;
    logic       w_push_next;
    logic [3:0] w_count_next;
    logic [3:0] w_k_next;

`ifdef PUSHPOP_TIMEOUT_EN
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
`endif

    // SP itself is updated by the datapath; its index is kept for reference only.
    logic [3:0] w_unused_sp;
    assign w_unused_sp = SP_REG;

    logic       w_hit;
    logic [8:0] w_list_in;
    logic [9:0][3:0] w_pc;
    logic [3:0] w_idx;
    logic [8:0] w_list_rest;
    logic       w_in_access;

    assign w_hit = instr_valid_i && (instr_i[15:12] == 4'b1011) && (instr_i[10:9] == 2'b10);
    assign w_list_in = instr_i[8:0];

    // Popcount of the incoming register list as a running prefix sum.
    assign w_pc[0] = 4'd0;
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_popcount
            assign w_pc[gi+1] = w_pc[gi] + {3'b000, w_list_in[gi]};
        end
    endgenerate

    // Lowest set bit of the remaining list selects the register served now.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (r_list[i]) w_idx = i[3:0];
        end
    end

    assign w_list_rest = r_list & ~(9'd1 << w_idx);
    assign w_in_access = (r_state == ACCESS);

    // Next-state and datapath-latch logic.
    always_comb begin
        w_state_next = r_state;
        w_list_next  = r_list;
        w_push_next  = r_push;
        w_count_next = r_count;
        w_k_next     = r_k;
`ifdef PUSHPOP_TIMEOUT_EN
        w_wait_next  = r_wait;
`endif
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_list_next  = w_list_in;
                    w_push_next  = ~instr_i[11];
                    w_count_next = w_pc[9];
                    w_k_next     = 4'd0;
`ifdef PUSHPOP_TIMEOUT_EN
                    w_wait_next  = '0;
`endif
                    if (w_pc[9] == 4'd0)  w_state_next = DONE;
                    else if (~instr_i[11]) w_state_next = SP_UPD;
                    else                   w_state_next = ACCESS;
                end
            end
            SP_UPD: begin
`ifdef PUSHPOP_TIMEOUT_EN
                w_wait_next  = '0;
`endif
                w_state_next = r_push ? ACCESS : DONE;
            end
            ACCESS: begin
                if (mem_ready_i) begin
                    w_list_next = w_list_rest;
                    w_k_next    = r_k + 4'd1;
`ifdef PUSHPOP_TIMEOUT_EN
                    w_wait_next = '0;
`endif
                    if (w_list_rest == 9'd0) w_state_next = r_push ? DONE : SP_UPD;
                end
`ifdef PUSHPOP_TIMEOUT_EN
                else if (r_wait == WAIT_W'(WAIT_LIMIT - 1)) begin
                    w_state_next = ABORT;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
`endif
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight instruction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_list  <= 9'd0;
            r_push  <= 1'b0;
            r_count <= 4'd0;
            r_k     <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_list  <= w_list_next;
            r_push  <= w_push_next;
            r_count <= w_count_next;
            r_k     <= w_k_next;
        end
    end

`ifdef PUSHPOP_TIMEOUT_EN
    // Consecutive not-ready cycles in ACCESS.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_wait <= '0;
        else          r_wait <= w_wait_next;
    end
    assign err_o = (r_state == ABORT);
`else
    assign err_o = 1'b0;
`endif

    // Output decode; the accept-cycle stall is gated by reset so every output is 0 in reset.
    always_comb begin
        stall_o       = ((r_state == IDLE) && w_hit && rst_n_i) ||
                        (r_state == SP_UPD) || w_in_access;
        busy_o        = (r_state != IDLE);
        mem_write_o   = w_in_access && r_push;
        mem_load_o    = w_in_access && !r_push;
        reg_sel_o     = 4'd0;
        off_o         = 6'd0;
        if (w_in_access) begin
            reg_sel_o = (w_idx == 4'd8) ? (r_push ? LR_REG : PC_REG) : w_idx;
            off_o     = {r_k, 2'b00};
        end
        rf_write_en_o = w_in_access && !r_push && mem_ready_i && (w_idx != 4'd8);
        pc_load_o     = w_in_access && !r_push && mem_ready_i && (w_idx == 4'd8);
        sp_write_en_o = (r_state == SP_UPD);
        sp_dec_o      = (r_state == SP_UPD) && r_push;
        sp_delta_o    = (r_state == SP_UPD) ? {r_count, 2'b00} : 6'd0;
        done_o        = (r_state == DONE);
    end

endmodule

// File: doc/pushpop_sequencer.md
# pushpop_sequencer

Multi-cycle sequencer for Thumb PUSH/POP register-list instructions. It sits beside the control unit, between fetch and the ALU/memory datapath. On a PUSH or POP it stalls fetch and issues one memory access per listed register, then applies a single SP update and releases the pipeline. It replaces the single-register self-instruct path with full 9-bit register-list support.

## Interface
- WAIT_LIMIT, 16: max consecutive cycles without `mem_ready_i` before abort (only with macro)
- SP_REG, 4'd13: stack pointer index
- LR_REG, 4'd14: link register index (PUSH, list bit 8)
- PC_REG, 4'd15: program counter index (POP, list bit 8)

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset; asynchronous and active-low
- instr_i  in  16  fetched instruction
- instr_valid_i  in  1  instr_i valid this cycle
- mem_ready_i  in  1  memory accepted the store / load data valid
- stall_o  out  1  hold fetch and PC
- busy_o  out  1  FSM not IDLE
- mem_write_o  out  1  store request
- mem_load_o  out  1  load request
- reg_sel_o  out  4  register read (PUSH) or written (POP)
- off_o  out  6  byte offset added to SP for address
- rf_write_en_o  out  1  register-file write (POP, r0–r7)
- pc_load_o  out  1  load PC from memory data (POP with PC)
- sp_write_en_o  out  1  SP update strobe
- sp_dec_o  out  1  1 = SP -= sp_delta_o, 0 = SP += sp_delta_o
- sp_delta_o  out  6  byte delta, 4 × count
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle timeout pulse; tied 0 without macro

## Operation
- Decode (IDLE only): `instr_i[15:12]==4'b1011 && instr_i[10:9]==2'b10`.
  - bit11 = 0 is PUSH, 1 is POP.
  - list = {instr_i[8], instr_i[7:0]}; count = popcount(list), range 0..9.
- States: IDLE, SP_UPD, ACCESS, DONE. An `ABORT` pulse exists only with the macro.
- IDLE:
  - On a decode hit, latch list, dir and count; assert stall_o combinationally in the same cycle.
  - count==0 → DONE.
  - PUSH → SP_UPD.
  - POP → ACCESS.
  - Non-matching instructions are ignored, and all outputs stay 0.
- SP_UPD: one cycle with sp_write_en_o=1 and sp_delta_o=4×count.
  - sp_dec_o=1 for PUSH, 0 for POP.
  - Next state: PUSH → ACCESS, POP → DONE.
- ACCESS: serves the lowest set bit of the remaining list.
  - reg_sel_o = bit index; bit 8 maps to LR_REG (PUSH) or PC_REG (POP).
  - off_o = 4×k, where k = accesses completed (0-based). Addresses ascend from the current SP.
  - mem_write_o (PUSH) or mem_load_o (POP) is held until mem_ready_i.
  - In the mem_ready_i cycle, POP asserts rf_write_en_o for r0–r7, or pc_load_o for PC. Then clear the bit and increment k.
  - List empty after this access → PUSH: DONE, POP: SP_UPD.
- DONE: done_o=1 and stall_o=0 for one cycle, then → IDLE.
- instr_valid_i is ignored outside IDLE.

## Timing
- Reset value of every output and state: 0 / IDLE.
- Reset mid-operation returns immediately to IDLE.
  - Completed stores are not undone.
  - The POP SP update is lost.
- With zero wait states, an n-register PUSH or POP has stall_o high for n+2 cycles (accept cycle + n ACCESS + SP_UPD). done_o follows in the next cycle.
- Each wait cycle (mem_ready_i=0 in ACCESS) adds exactly one cycle. Outputs stay stable while waiting.
- Empty list: accept cycle, then DONE. No memory access, no SP write.
- k ≤ 8, so off_o ≤ 32; 4×count ≤ 36 fits 6 bits.

## Configuration
- `PUSHPOP_TIMEOUT_EN` defined:
  - A wait counter is cleared on each ACCESS entry and on each mem_ready_i.
  - When it reaches WAIT_LIMIT cycles, the block pulses err_o for one cycle and returns to IDLE. It drops stall_o, issues no SP update and no done_o.
- Not defined: no counter, err_o tied 0, and ACCESS waits indefinitely.

## Test plan
- PUSH 0xB505 (r0, r2, LR), mem_ready_i=1 → SP_UPD with sp_dec_o=1, sp_delta_o=12. Then stores (reg, off): (0,0), (2,4), (14,8). done_o 5 cycles after accept.
- POP 0xBD02 (r1, PC) → loads (1,0) with rf_write_en_o, then (15,4) with pc_load_o. Then SP_UPD with sp_dec_o=0, sp_delta_o=8, then done_o.
- PUSH 0xB400 (empty) → stall_o for 1 cycle, no memory request, no SP write, done_o next cycle.
- POP 0xBC80 (r7) with mem_ready_i low for 3 cycles → mem_load_o held 4 cycles with reg_sel_o=7. rf_write_en_o only in the ready cycle.
- Macro on, WAIT_LIMIT=16, PUSH 0xB401 with mem_ready_i stuck low → err_o pulse after 16 wait cycles, return to IDLE, no done_o.
- 0x2011 (MOV imm) with instr_valid_i=1 → stall_o, busy_o and all strobes stay 0. rst_n_i low mid-PUSH → all outputs 0 asynchronously.
